// File: rtl/ahb_pkg.sv
// ahb_pkg: shared AHB-Lite encodings and slave protocol states
package ahb_pkg;
   localparam logic [1:0] HTRANS_IDLE   = 2'b00;
   localparam logic [1:0] HTRANS_BUSY   = 2'b01;
   localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
   localparam logic [1:0] HTRANS_SEQ    = 2'b11;
   localparam logic HRESP_OKAY  = 1'b0;
   localparam logic HRESP_ERROR = 1'b1;
   localparam logic [2:0] HSIZE_WORD = 3'b010;
   typedef enum logic [2:0] {IDLE, WAIT, DATA, ERR1, ERR2} state_t;
endpackage

// File: rtl/ahb_slave_mem_if.sv
// ahb_slave_mem_if: AHB-Lite slot signals between decoder/mux and one slave
interface ahb_slave_mem_if #(
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32
);
   logic              hsel;
   logic [ADDR_W-1:0] haddr;
   logic [1:0]        htrans;
   logic              hwrite;
   logic [2:0]        hsize;
   logic [DATA_W-1:0] hwdata;
   logic              hready;
   logic              hreadyout;
   logic              hresp;
   logic [DATA_W-1:0] hrdata;
   modport master (output hsel, haddr, htrans, hwrite, hsize, hwdata, hready,
                   input hreadyout, hresp, hrdata);
   modport slave (input hsel, haddr, htrans, hwrite, hsize, hwdata, hready,
                  output hreadyout, hresp, hrdata);
endinterface

// File: rtl/ahb_slave_regfile.sv
// ahb_slave_regfile: word memory with synchronous write and asynchronous read
module ahb_slave_regfile #(
   parameter int DEPTH  = 16,
   parameter int DATA_W = 32
) (
   input  logic                     hclk,
   input  logic                     hreset,
   input  logic                     we,
   input  logic [$clog2(DEPTH)-1:0] waddr,
   input  logic [DATA_W-1:0]        wdata,
   input  logic [$clog2(DEPTH)-1:0] raddr,
   output logic [DATA_W-1:0]        rdata
);
   logic [DATA_W-1:0] mem [DEPTH];
   always_ff @(posedge hclk)
      if (hreset) mem <= '{default: '0};
      else if (we) mem[waddr] <= wdata;
   assign rdata = mem[raddr];
endmodule

// File: rtl/ahb_slave_mem.sv
// ahb_slave_mem: pipelined AHB-Lite memory slave with wait states and
// two-cycle ERROR response for misaligned, non-word or out-of-range accesses
module ahb_slave_mem
   import ahb_pkg::*;
#(
   parameter int ADDR_W      = 32,
   parameter int DATA_W      = 32,
   parameter int DEPTH       = 16,
   parameter int WAIT_STATES = 1
) (
   input logic            hclk,
   input logic            hreset,
   ahb_slave_mem_if.slave bus
);
   localparam int AW = $clog2(DEPTH);
   state_t          state, state_n;
   logic [2:0]      cnt, cnt_n;
   logic [AW-1:0]   idx, idx_n;
   logic            wr, wr_n;
   logic            accept, illegal;
   logic [DATA_W-1:0] rdata;
   // new address phases only count while this slave is driving ready high
   assign accept  = (state inside {IDLE, DATA, ERR2}) & bus.hsel & bus.hready & bus.htrans[1];
   assign illegal = (bus.haddr[1:0] != 2'b00) | (bus.hsize != HSIZE_WORD) |
                    ((bus.haddr >> 2) >= ADDR_W'(DEPTH));
   always_ff @(posedge hclk)
      if (hreset) begin
         state <= IDLE;
         cnt   <= '0;
         idx   <= '0;
         wr    <= 1'b0;
      end else begin
         state <= state_n;
         cnt   <= cnt_n;
         idx   <= idx_n;
         wr    <= wr_n;
      end
   always_comb begin
      state_n = accept ? (illegal ? ERR1 : (WAIT_STATES > 0) ? WAIT : DATA) :
                state == WAIT ? (cnt <= 3'd1 ? DATA : WAIT) :
                state == ERR1 ? ERR2 : IDLE;
      cnt_n   = accept ? 3'(WAIT_STATES) : state == WAIT ? cnt - 3'd1 : cnt;
      idx_n   = accept ? bus.haddr[AW+1:2] : idx;
      wr_n    = accept ? bus.hwrite : wr;
   end
   ahb_slave_regfile #(.DEPTH(DEPTH), .DATA_W(DATA_W)) u_regfile (
      .hclk   (hclk),
      .hreset (hreset),
      .we     (state == DATA && wr),
      .waddr  (idx),
      .wdata  (bus.hwdata),
      .raddr  (idx),
      .rdata  (rdata)
   );
   assign bus.hreadyout = !(state inside {WAIT, ERR1});
   assign bus.hresp     = (state inside {ERR1, ERR2}) ? HRESP_ERROR : HRESP_OKAY;
   assign bus.hrdata    = (state == DATA && !wr) ? rdata : '0;
endmodule

// File: tb/tb_ahb_slave_mem.sv
// tb_ahb_slave_mem: directed checks of the AHB memory slave with one and zero wait states
module tb_ahb_slave_mem;
   import ahb_pkg::*;
   logic hclk = 1'b0;
   logic hreset = 1'b1;
   int checks = 0;
   int errors = 0;
   always #5 hclk = ~hclk;
   ahb_slave_mem_if a ();
   ahb_slave_mem_if b ();
   assign a.hready = a.hreadyout;
   assign b.hready = b.hreadyout;
   ahb_slave_mem #(.WAIT_STATES(1)) dut_a (.hclk(hclk), .hreset(hreset), .bus(a));
   ahb_slave_mem #(.WAIT_STATES(0)) dut_b (.hclk(hclk), .hreset(hreset), .bus(b));

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic step;
      @(negedge hclk);
   endtask

   task automatic a_addr(input logic [31:0] ad, input logic wr, input logic [2:0] sz);
      a.hsel = 1'b1; a.haddr = ad; a.htrans = HTRANS_NONSEQ; a.hwrite = wr; a.hsize = sz;
   endtask

   task automatic a_idle;
      a.hsel = 1'b0; a.htrans = HTRANS_IDLE;
   endtask

   // full transfer on the one-wait-state slave: address phase, then two data-phase cycles
   task automatic a_xfer(input string tag, input logic [31:0] ad, input logic wr,
                         input logic [2:0] sz, input logic [31:0] wd, input logic err,
                         input logic [31:0] rd);
      a_addr(ad, wr, sz);
      step;
      a_idle;
      a.hwdata = wd;
      chk({tag, "_c1_rdy"}, 32'(a.hreadyout), 32'd0);
      chk({tag, "_c1_resp"}, 32'(a.hresp), 32'(err));
      chk({tag, "_c1_rdata"}, a.hrdata, 32'd0);
      step;
      chk({tag, "_c2_rdy"}, 32'(a.hreadyout), 32'd1);
      chk({tag, "_c2_resp"}, 32'(a.hresp), 32'(err));
      chk({tag, "_c2_rdata"}, a.hrdata, (err || wr) ? 32'd0 : rd);
      step;
   endtask

   initial begin
      a_idle; a.haddr = '0; a.hwrite = 1'b0; a.hsize = HSIZE_WORD; a.hwdata = '0;
      b.hsel = 1'b0; b.htrans = HTRANS_IDLE; b.haddr = '0; b.hwrite = 1'b0;
      b.hsize = HSIZE_WORD; b.hwdata = '0;
      repeat (2) @(posedge hclk);
      step;
      hreset = 1'b0;
      chk("rst_rdy", 32'(a.hreadyout), 32'd1);
      chk("rst_resp", 32'(a.hresp), 32'd0);
      chk("rst_rdata", a.hrdata, 32'd0);
      chk("rst_b_rdy", 32'(b.hreadyout), 32'd1);
      // basic write then read with one wait state
      a_xfer("wr8", 32'h8, 1'b1, HSIZE_WORD, 32'h0000_0007, 1'b0, 32'h0);
      a_xfer("rd8", 32'h8, 1'b0, HSIZE_WORD, 32'h0, 1'b0, 32'h0000_0007);
      // zero wait states, read pipelined right behind write to the same word
      b.hsel = 1'b1; b.haddr = 32'h4; b.htrans = HTRANS_NONSEQ; b.hwrite = 1'b1;
      step;
      b.hwdata = 32'hA5A5_A5A5; b.hwrite = 1'b0;
      chk("b_wr_rdy", 32'(b.hreadyout), 32'd1);
      chk("b_wr_rdata", b.hrdata, 32'd0);
      step;
      b.hsel = 1'b0; b.htrans = HTRANS_IDLE;
      chk("b_rd_data", b.hrdata, 32'hA5A5_A5A5);
      chk("b_rd_resp", 32'(b.hresp), 32'd0);
      chk("b_rd_rdy", 32'(b.hreadyout), 32'd1);
      step;
      chk("b_idle_rdata", b.hrdata, 32'd0);
      // out-of-range index, then a legal access still completes OKAY
      a_xfer("rd40", 32'h40, 1'b0, HSIZE_WORD, 32'h0, 1'b1, 32'h0);
      a_xfer("rd0", 32'h0, 1'b0, HSIZE_WORD, 32'h0, 1'b0, 32'h0);
      a_xfer("rd8b", 32'h8, 1'b0, HSIZE_WORD, 32'h0, 1'b0, 32'h0000_0007);
      // illegal size and misaligned writes must not touch memory
      a_xfer("wr4", 32'h4, 1'b1, HSIZE_WORD, 32'h0000_0011, 1'b0, 32'h0);
      a_xfer("wr4_half", 32'h4, 1'b1, 3'b001, 32'hDEAD_DEAD, 1'b1, 32'h0);
      a_xfer("wr6", 32'h6, 1'b1, HSIZE_WORD, 32'hBEEF_BEEF, 1'b1, 32'h0);
      a_xfer("rd4", 32'h4, 1'b0, HSIZE_WORD, 32'h0, 1'b0, 32'h0000_0011);
      // unselected NONSEQ and selected BUSY are ignored
      a_addr(32'h8, 1'b1, HSIZE_WORD);
      a.hsel = 1'b0;
      step;
      a.hwdata = 32'hFFFF_FFFF;
      chk("nosel_rdy", 32'(a.hreadyout), 32'd1);
      chk("nosel_resp", 32'(a.hresp), 32'd0);
      a_addr(32'h8, 1'b1, HSIZE_WORD);
      a.htrans = HTRANS_BUSY;
      step;
      a_idle;
      chk("busy_rdy", 32'(a.hreadyout), 32'd1);
      chk("busy_resp", 32'(a.hresp), 32'd0);
      step;
      a_xfer("rd8c", 32'h8, 1'b0, HSIZE_WORD, 32'h0, 1'b0, 32'h0000_0007);
      // reset during the wait cycle of a write aborts it
      a_addr(32'hC, 1'b1, HSIZE_WORD);
      step;
      a_idle;
      a.hwdata = 32'h0000_1234;
      hreset = 1'b1;
      chk("rstw_wait_rdy", 32'(a.hreadyout), 32'd0);
      step;
      hreset = 1'b0;
      chk("rstw_rdy", 32'(a.hreadyout), 32'd1);
      chk("rstw_resp", 32'(a.hresp), 32'd0);
      chk("rstw_rdata", a.hrdata, 32'd0);
      a_xfer("rdC", 32'hC, 1'b0, HSIZE_WORD, 32'h0, 1'b0, 32'h0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule

// File: doc/ahb_slave_mem.md
Name: ahb_slave_mem

Overview:
- AHB-Lite responder (slave) holding a small word-addressed memory; it is the far end of the master request path driven by the masters in ahb_top.
- One instance per slave slot behind the address decoder/mux; four instances populate slots 0-3.
- Fully pipelined address/data phases, programmable wait states, two-cycle ERROR response for illegal accesses.

Parameters:
- ADDR_W, 32, haddr width
- DATA_W, 32, hwdata/hrdata width
- DEPTH, 16, number of DATA_W words (power of 2)
- WAIT_STATES, 1, hreadyout-low cycles inserted in every OKAY NONSEQ/SEQ data phase (0..7)

Ports:
- hclk  in  1  clock; all logic on rising edge
- hreset  in  1  synchronous, active-high reset
- hsel  in  1  slot select from decoder
- haddr  in  ADDR_W  byte address
- htrans  in  2  IDLE=00, BUSY=01, NONSEQ=10, SEQ=11
- hwrite  in  1  1=write, 0=read
- hsize  in  3  transfer size; only 3'b010 (word) legal
- hwdata  in  DATA_W  write data (data phase)
- hready  in  1  bus-level ready (previous transfer completing)
- hreadyout  out  1  this slave's ready
- hresp  out  1  0=OKAY, 1=ERROR
- hrdata  out  DATA_W  read data

Behaviour:
- Reset (hreset=1 at an edge): state=IDLE, hreadyout=1, hresp=0, hrdata=0, all memory words=0, latched address/control cleared. Reset mid-wait or mid-error aborts the transfer; a pending write is not committed.
- Address phase accepted when hsel & hready & htrans[1] at a rising edge; latch word index haddr[log2(DEPTH)+1:2], hwrite.
- Illegal access = haddr[1:0]!=0, OR hsize!=3'b010, OR haddr>>2 >= DEPTH. Illegal accesses are decided at address acceptance.
- hsel & hready with htrans IDLE/BUSY: no state change; zero-wait OKAY (hreadyout=1, hresp=0).
- States:
  - IDLE: hreadyout=1, hresp=0. Legal accept with WAIT_STATES>0 goes to WAIT (counter=WAIT_STATES). Legal accept with WAIT_STATES=0 goes to DATA. Illegal accept goes to ERR1.
  - WAIT: hreadyout=0, hresp=0; counter decrements each cycle; at 1, go to DATA.
  - DATA: hreadyout=1, hresp=0. Write: hwdata committed to mem[index] at the end of this cycle. Read: hrdata=mem[index] (combinational) during this cycle. Exits to IDLE, or directly to WAIT/DATA/ERR1 if a new transfer is accepted on the same edge (pipelined back-to-back).
  - ERR1: hreadyout=0, hresp=1. Always goes to ERR2.
  - ERR2: hreadyout=1, hresp=1; no memory access. Next state follows the IDLE accept rules (new transfer may be accepted).
- hrdata=0 whenever not in a read DATA cycle.
- Latency: OKAY transfer data phase = WAIT_STATES+1 cycles; ERROR = exactly 2 cycles regardless of WAIT_STATES.
- Read-after-write to the same index back-to-back: the read returns the newly written data (write commits before the read's DATA cycle).
- New address phases are ignored while hreadyout=0, because hready is then low at bus level.
- hsel low in IDLE: outputs at idle values; hsel is not re-checked in data phase.

Decomposition:
- Package ahb_pkg: HTRANS_IDLE/BUSY/NONSEQ/SEQ, HRESP_OKAY/ERROR, HSIZE_WORD, state enum {IDLE, WAIT, DATA, ERR1, ERR2}.
- One sub-module: ahb_slave_regfile (DEPTH x DATA_W, sync write with enable, async read, sync clear on hreset).
- Protocol FSM and wait counter stay in ahb_slave_mem.

Test Plan:
- Default params: NONSEQ write addr 0x8, data 0x0000_0007, then NONSEQ read addr 0x8 -> each data phase 2 cycles (hreadyout 0 then 1); read hrdata=0x7, hresp=0.
- WAIT_STATES=0, pipelined write 0x4=0xA5A5_A5A5 followed immediately by read 0x4 -> write data phase 1 cycle; next cycle hrdata=0xA5A5_A5A5.
- Read addr 0x40 (index 16 >= DEPTH) -> hreadyout=0/hresp=1, then hreadyout=1/hresp=1; memory unchanged; next legal read addr 0x0 returns OKAY.
- hsize=3'b001 or haddr=0x6 -> two-cycle ERROR; write data not stored (read of 0x4 returns prior value).
- hsel=0 with NONSEQ, and hsel=1 with htrans=BUSY -> hreadyout stays 1, hresp=0, no memory change.
- hreset asserted during the WAIT cycle of write 0xC=0x1234 -> next cycle hreadyout=1, hresp=0, hrdata=0; read 0xC returns 0.
